// File: rtl/rx_header_queue_pkg.sv
// Shared definitions for the receive header queue.
// Holds the header geometry (5 words), the word index of every header field,
// the service FSM state encoding and a saturating counter helper.
package rx_header_queue_pkg;

    localparam int HDR_WORDS = 5;

    // Word position of each field inside an assembled header
    localparam int HDR_SRC = 0;
    localparam int HDR_DST = 1;
    localparam int HDR_BAT = 2;
    localparam int HDR_VAL = 3;
    localparam int HDR_CLU = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } svc_state_e;

    // 8-bit increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rx_header_queue_if.sv
// Word stream from the radio interface into the header queue.
//   rx_data  : header word
//   rx_valid : rx_data valid
//   rx_last  : final word of a header
//   rx_ready : receiver can accept a word
// A word transfers on a rising clock edge where rx_valid && rx_ready.
interface rx_header_queue_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_last;
    logic                  rx_ready;

    // Radio side drives words, sees back-pressure
    modport master (
        output rx_data,
        output rx_valid,
        output rx_last,
        input  rx_ready
    );

    // Queue side consumes words, drives back-pressure
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_last,
        output rx_ready
    );
endinterface

// File: rtl/rx_header_queue_hdr_fifo.sv
// Small synchronous FIFO of complete headers.
// Ports:
//   clock, nrst : clock and asynchronous active-low reset
//   push, din   : write one entry (ignored when full)
//   pop, dout   : dout shows the head entry; pop removes it (ignored when empty)
//   full, empty : occupancy flags
//   level       : number of entries held
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module hdr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 80
) (
    input  logic                     clock,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_en_s;
    logic             pop_en_s;

    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign level = wr_ptr_r - rd_ptr_r;
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    assign push_en_s = push & ~full;
    assign pop_en_s  = pop & ~empty;

    // Storage and pointer update; push and pop in one cycle are both taken
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/rx_header_queue.sv
// Receive header queue: assembles 5-word headers from the radio word stream,
// buffers complete headers, and presents them one at a time to the routing
// pipeline as stable field registers qualified by a level 'start'.
// Ports:
//   clock, nrst       : clock, asynchronous active-low reset
//   rx (slave)        : rx_data / rx_valid / rx_last in, rx_ready out
//   pipe_done         : pipeline finished the header in service
//   pipe_abort        : pipeline dropped the header early
//   start             : high while a header is in service
//   fsourceID..fclusterID : fields of the header in service (words 0..4)
//   drop_count        : malformed headers dropped, saturating at 255
//   q_level           : headers waiting in the FIFO (not counting in-service)
module rx_header_queue
    import rx_header_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int WORD_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    nrst,
    rx_header_queue_if.slave        rx,
    input  logic                    pipe_done,
    input  logic                    pipe_abort,
    output logic                    start,
    output logic [WORD_WIDTH-1:0]   fsourceID,
    output logic [WORD_WIDTH-1:0]   fdestinationID,
    output logic [WORD_WIDTH-1:0]   fbatteryStat,
    output logic [WORD_WIDTH-1:0]   fValue,
    output logic [WORD_WIDTH-1:0]   fclusterID,
    output logic [7:0]              drop_count,
    output logic [$clog2(DEPTH):0]  q_level
);
    localparam int          HDR_BITS = HDR_WORDS * WORD_WIDTH;
    localparam logic [2:0]  LAST_IDX = 3'(HDR_WORDS - 1);

    // Assembler state
    logic [WORD_WIDTH-1:0]  stage_r [HDR_WORDS];
    logic [2:0]             idx_r;
    logic                   skip_r;      // discarding the tail of an over-long header
    logic [7:0]             drop_r;
    logic                   ready_en_r;  // holds rx_ready low until the first edge after reset

    // Service state
    svc_state_e             state_r;
    logic                   start_r;
    logic [WORD_WIDTH-1:0]  src_r;
    logic [WORD_WIDTH-1:0]  dst_r;
    logic [WORD_WIDTH-1:0]  bat_r;
    logic [WORD_WIDTH-1:0]  val_r;
    logic [WORD_WIDTH-1:0]  clu_r;

    logic                   rx_ready_s;
    logic                   xfer_s;
    logic                   push_s;
    logic                   pop_s;
    logic [HDR_BITS-1:0]    push_hdr_s;
    logic [HDR_BITS-1:0]    fifo_dout_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_level_s;

    assign rx_ready_s = ready_en_r & ~fifo_full_s;
    assign rx.rx_ready = rx_ready_s;
    assign xfer_s     = rx.rx_valid & rx_ready_s;

    // Final word goes straight from the bus into the FIFO on the same edge
    always_comb begin
        push_hdr_s = {rx.rx_data, stage_r[3], stage_r[2], stage_r[1], stage_r[0]};
        if (xfer_s && !skip_r && (idx_r == LAST_IDX) && rx.rx_last) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // The head is taken only while the service FSM is idle
    always_comb begin
        if ((state_r == IDLE) && !fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    hdr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (HDR_BITS)
    ) u_hdr_fifo (
        .clock (clock),
        .nrst  (nrst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_hdr_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Header assembler: word staging, short/long header detection, drop counting
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            idx_r      <= 3'd0;
            skip_r     <= 1'b0;
            drop_r     <= 8'd0;
            ready_en_r <= 1'b0;
            for (int i = 0; i < HDR_WORDS; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            ready_en_r <= 1'b1;
            if (xfer_s) begin
                if (skip_r) begin
                    // The terminating rx_last of a long header was already counted
                    if (rx.rx_last) begin
                        skip_r <= 1'b0;
                    end
                end else begin
                    stage_r[idx_r] <= rx.rx_data;
                    if (idx_r == LAST_IDX) begin
                        idx_r <= 3'd0;
                        if (!rx.rx_last) begin
                            skip_r <= 1'b1;
                            drop_r <= sat_inc8(drop_r);
                        end
                    end else if (rx.rx_last) begin
                        idx_r  <= 3'd0;
                        drop_r <= sat_inc8(drop_r);
                    end else begin
                        idx_r <= idx_r + 3'd1;
                    end
                end
            end
        end
    end

    // Service FSM: load head into fields, hold start until done/abort, one-cycle gap
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
            start_r <= 1'b0;
            src_r   <= '0;
            dst_r   <= '0;
            bat_r   <= '0;
            val_r   <= '0;
            clu_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        src_r   <= fifo_dout_s[HDR_SRC*WORD_WIDTH +: WORD_WIDTH];
                        dst_r   <= fifo_dout_s[HDR_DST*WORD_WIDTH +: WORD_WIDTH];
                        bat_r   <= fifo_dout_s[HDR_BAT*WORD_WIDTH +: WORD_WIDTH];
                        val_r   <= fifo_dout_s[HDR_VAL*WORD_WIDTH +: WORD_WIDTH];
                        clu_r   <= fifo_dout_s[HDR_CLU*WORD_WIDTH +: WORD_WIDTH];
                        start_r <= 1'b1;
                        state_r <= ISSUE;
                    end
                end
                ISSUE: begin
                    // done and abort together are a single completion
                    if (pipe_done || pipe_abort) begin
                        start_r <= 1'b0;
                        state_r <= RELEASE;
                    end
                end
                RELEASE: begin
                    // start stays low here so downstream done flags can clear
                    state_r <= IDLE;
                end
                default: begin
                    start_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign start          = start_r;
    assign fsourceID      = src_r;
    assign fdestinationID = dst_r;
    assign fbatteryStat   = bat_r;
    assign fValue         = val_r;
    assign fclusterID     = clu_r;
    assign drop_count     = drop_r;
    assign q_level        = fifo_level_s;

endmodule

// File: doc/rx_header_queue.md
Name: rx_header_queue

Overview:
- Upstream stage of learnCosts.
- Accepts 16-bit words of received packet headers from the radio interface over a valid/ready handshake, and assembles 5-word headers.
- Queues complete headers in a small FIFO.
- Presents one header at a time to the routing pipeline (learnCosts → … → winnerPolicy) as stable field registers plus a level `start`.
- Releases the header when the pipeline reports completion or an early abort.

Parameters:
- DEPTH, 4, number of queued headers; power of two, ≥2.
- WORD_WIDTH, 16, header word width (matches `WORD_WIDTH).

Ports:
- clock  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- rx_data  input  16  header word from radio.
- rx_valid  input  1  rx_data valid.
- rx_last  input  1  marks final word of a header.
- rx_ready  output  1  block can accept a word.
- pipe_done  input  1  routing pipeline finished current header (done_winnerPolicy).
- pipe_abort  input  1  pipeline discarded header early (sink / not forwarding).
- start  output  1  level; header in service.
- fsourceID  output  16  header word 0.
- fdestinationID  output  16  header word 1.
- fbatteryStat  output  16  header word 2.
- fValue  output  16  header word 3.
- fclusterID  output  16  header word 4.
- drop_count  output  8  malformed headers dropped; saturating.
- q_level  output  log2(DEPTH)+1  headers currently queued, excluding the one in service.

Behaviour:
- Reset: applies asynchronously on nrst low, mid-packet or mid-service included. Effects:
  - all outputs 0, rx_ready 0 while nrst low;
  - FIFO emptied, assembler word index 0, FSM IDLE;
  - the partial header in assembly is discarded without counting as a drop.
- Handshake:
  - A word transfers on a rising edge with rx_valid && rx_ready.
  - rx_ready = !fifo_full after reset release.
  - rx_data/rx_last are ignored when not transferring.
- Assembler:
  - Holds 5 staging registers and a 3-bit index.
  - Transferred word is written to staging[index].
  - Word 4 with rx_last=1: the complete header is pushed into the FIFO in that same edge, and the index returns to 0.
  - rx_last=1 on index 0..3 (short header): discard, index→0, drop_count+1.
  - rx_last=0 on index 4 (long header): discard, index→0, drop_count+1, and ignore every following word up to and including the next rx_last=1. That trailing rx_last does not add a second drop.
  - drop_count saturates at 255.
- FIFO: DEPTH × 80 bits, with read/write pointers one bit wider than log2(DEPTH) for full/empty. Push and pop in the same cycle are both honoured; level is unchanged.
- Service FSM (2-bit state):
  - IDLE: if FIFO not empty, pop the head into the field registers and go to ISSUE. Fields are valid on the cycle start rises, i.e. 1 clock after the FIFO goes non-empty.
  - ISSUE: start=1. Field registers held constant. Stay until pipe_done || pipe_abort is sampled high, then go to RELEASE. pipe_done and pipe_abort together are treated as one completion. Either asserted in IDLE or RELEASE is ignored.
  - RELEASE: start=0 for exactly one cycle so downstream done flags clear. Field registers keep their last values. Next state is IDLE.
  - Minimum header-to-header start gap: 2 cycles of start low (RELEASE + IDLE).
- Full boundary: when the FIFO is full, rx_ready drops in the cycle after the push that filled it. Incoming words stall and are not dropped. rx_ready returns 1 in the cycle after the IDLE pop.
- Empty boundary: the FSM waits in IDLE with start=0. Fields retain their last values.
- q_level counts FIFO occupancy only.

Decomposition:
- Shared include file (alongside the existing `define header): HDR_WORDS=5; field index constants HDR_SRC=0, HDR_DST=1, HDR_BAT=2, HDR_VAL=3, HDR_CLU=4; FSM state encodings IDLE=0, ISSUE=1, RELEASE=2.
- One sub-module: hdr_fifo. Parameters DEPTH and WIDTH=80. Ports: push, pop, din, dout, full, empty, level. Asynchronous active-low reset.
- The assembler and the service FSM stay in rx_header_queue.

Test Plan:
- Single header: send 1, 3, 0x8000, 10, 1 with rx_last on word 4 → 1 cycle later start=1, fsourceID=1, fdestinationID=3, fbatteryStat=0x8000, fValue=10, fclusterID=1. pipe_done pulse → start=0 next cycle and q_level=0.
- Fill: DEPTH=4 with no pipe_done, send 6 headers back-to-back → one header in service, q_level=4, rx_ready=0. Words of the 6th header stall and are not lost. After pipe_done, 2 cycles of start low, then header 2 fields presented.
- Malformed: rx_last on word 2 → drop_count=1, nothing queued. A 7-word header with rx_last on word 6 → drop_count=2, nothing queued. A following valid header is accepted normally.
- Abort: pipe_abort high during ISSUE with a second header queued → start low 2 cycles, then the second header's fields are presented. pipe_done and pipe_abort asserted together → single release.
- Reset mid-operation: nrst low after word 2 of a header, with 2 queued → immediately start=0, q_level=0, drop_count=0. After release, a fresh header is accepted as word 0.
- Simultaneous: push completes on the same edge as the IDLE pop with FIFO at level 1 → q_level stays 1 and field values equal the older header.
